// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared FSM state, pixel type and colour-bar palette for the timing source
package video_timing_pkg;

  typedef enum logic [1:0] {SEEK, ARM, RUN} vtg_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb888_t CBAR_WHITE   = 24'hFFFFFF;
  localparam rgb888_t CBAR_YELLOW  = 24'hFFFF00;
  localparam rgb888_t CBAR_CYAN    = 24'h00FFFF;
  localparam rgb888_t CBAR_GREEN   = 24'h00FF00;
  localparam rgb888_t CBAR_MAGENTA = 24'hFF00FF;
  localparam rgb888_t CBAR_RED     = 24'hFF0000;
  localparam rgb888_t CBAR_BLUE    = 24'h0000FF;
  localparam rgb888_t CBAR_BLACK   = 24'h000000;

  function automatic rgb888_t cbar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return CBAR_WHITE;
      3'd1:    return CBAR_YELLOW;
      3'd2:    return CBAR_CYAN;
      3'd3:    return CBAR_GREEN;
      3'd4:    return CBAR_MAGENTA;
      3'd5:    return CBAR_RED;
      3'd6:    return CBAR_BLUE;
      default: return CBAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// rtl/video_timing_cnt.sv - free-running h/v raster counters and region decode
// VTG_COLORBAR_EN adds the pix_x output (column inside the active window).
module video_timing_cnt #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 2,
  parameter int H_BP      = 2,
  parameter int H_FP      = 2,
  parameter int V_SYNC    = 1,
  parameter int V_BP      = 1,
  parameter int V_FP      = 1,
  localparam int H_TOTAL  = H_SYNC + H_BP + IMG_HDISP + H_FP,
  localparam int V_TOTAL  = V_SYNC + V_BP + IMG_VDISP + V_FP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VTG_COLORBAR_EN
  output logic [HW-1:0] pix_x,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          first_pix,
  output logic          frame_start
);

  localparam int H_ACT = H_SYNC + H_BP;
  localparam int V_ACT = V_SYNC + V_BP;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_act;
  logic          v_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    h_act       = (h_cnt >= HW'(H_ACT)) && (h_cnt < HW'(H_ACT + IMG_HDISP));
    v_act       = (v_cnt >= VW'(V_ACT)) && (v_cnt < VW'(V_ACT + IMG_VDISP));
    hsync       = h_cnt < HW'(H_SYNC);
    vsync       = v_cnt < VW'(V_SYNC);
    active      = h_act && v_act;
    first_pix   = (h_cnt == HW'(H_ACT)) && (v_cnt == VW'(V_ACT));
    frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VTG_COLORBAR_EN
  assign pix_x = h_cnt - HW'(H_ACT);
`endif

endmodule

// File: rtl/video_stream_timing_src.sv
// rtl/video_stream_timing_src.sv - pixel stream to DE/HSYNC/VSYNC source, frame-locked by s_sof
// VTG_COLORBAR_EN adds input cbar_en, which replaces the stream with eight vertical colour bars.
module video_stream_timing_src #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 2,
  parameter int H_BP      = 2,
  parameter int H_FP      = 2,
  parameter int V_SYNC    = 1,
  parameter int V_BP      = 1,
  parameter int V_FP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic [23:0] s_data,
  output logic        s_ready,
  output logic        video_vsync,
  output logic        video_hsync,
  output logic        video_de,
  output logic [23:0] video_data,
  input  logic        sts_clr,
`ifdef VTG_COLORBAR_EN
  input  logic        cbar_en,
`endif
  output logic        sts_underflow,
  output logic        sts_misalign
);
  import video_timing_pkg::*;

  vtg_state_t  state;
  logic        hsync, vsync, active, first_pix, frame_start;
  logic        cbar, accept, underflow_set, misplaced;
  logic [23:0] bar_data;

`ifdef VTG_COLORBAR_EN
  localparam int H_TOTAL = H_SYNC + H_BP + IMG_HDISP + H_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int BAR_W   = IMG_HDISP / 8;
  logic [HW-1:0] pix_x;
  logic [2:0]    bar_idx;

  assign cbar = cbar_en;
  // The last bar absorbs any remainder columns when IMG_HDISP is not a multiple of 8.
  always_comb begin
    bar_idx = 3'd7;
    if ((int'(pix_x) / BAR_W) < 7) bar_idx = 3'(int'(pix_x) / BAR_W);
    bar_data = cbar_color(bar_idx);
  end
`else
  assign cbar     = 1'b0;
  assign bar_data = 24'h0;
`endif

  video_timing_cnt #(
    .IMG_HDISP(IMG_HDISP), .IMG_VDISP(IMG_VDISP),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
`ifdef VTG_COLORBAR_EN
    .pix_x      (pix_x),
`endif
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active),
    .first_pix  (first_pix),
    .frame_start(frame_start)
  );

  // In RUN a beat whose SOF tag disagrees with the pixel position is refused, so it can re-seed SEEK.
  always_comb begin
    s_ready = 1'b0;
    if (!rst && !cbar) begin
      case (state)
        SEEK:    s_ready = ~s_sof;
        RUN:     s_ready = active & (s_sof == first_pix);
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign accept        = s_valid & s_ready;
  assign underflow_set = ~cbar & (state == RUN) & active & ~s_valid;
  assign misplaced     = ~cbar & (state == RUN) & active & s_valid & (s_sof != first_pix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEEK;
      video_vsync   <= 1'b0;
      video_hsync   <= 1'b0;
      video_de      <= 1'b0;
      video_data    <= 24'h0;
      sts_underflow <= 1'b0;
      sts_misalign  <= 1'b0;
    end else begin
      video_vsync <= vsync;
      video_hsync <= hsync;
      video_de    <= active;
      video_data  <= 24'h0;
      if (cbar) begin
        if (active) video_data <= bar_data;
      end else if (state == RUN && accept) begin
        video_data <= s_data;
      end
      sts_underflow <= underflow_set | (sts_underflow & ~sts_clr);
      sts_misalign  <= misplaced | (sts_misalign & ~sts_clr);
      if (cbar) begin
        state <= SEEK;
      end else begin
        case (state)
          SEEK:    if (s_valid && s_sof) state <= ARM;
          ARM:     if (frame_start) state <= RUN;
          RUN:     if (misplaced) state <= SEEK;
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_stream_timing_src.sv
// tb/tb_video_stream_timing_src.sv - directed/randomized bench with raster reference for video_stream_timing_src
`timescale 1ns/1ps
module tb_video_stream_timing_src;

  localparam int HD   = 8;
  localparam int VD   = 4;
  localparam int HT   = 14;
  localparam int VT   = 7;
  localparam int FR   = HT * VT;
  localparam int NPIX = HD * VD;
  localparam int NFR  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic [23:0] s_data = 24'h0;
  logic        s_ready;
  logic        video_vsync, video_hsync, video_de;
  logic [23:0] video_data;
  logic        sts_clr = 1'b0;
  logic        sts_underflow, sts_misalign;
`ifdef VTG_COLORBAR_EN
  logic        cbar_en = 1'b0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  typedef struct {
    logic [23:0] d;
    logic        sof;
  } beat_t;

  beat_t       q[$];
  logic [23:0] bd[$];
  logic [31:0] cap  [NFR*NPIX];
  logic [31:0] expv [NFR*NPIX];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          gap_cyc = -1;
  int          clr_cyc = -1;

  video_stream_timing_src #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_sof        (s_sof),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .video_vsync  (video_vsync),
    .video_hsync  (video_hsync),
    .video_de     (video_de),
    .video_data   (video_data),
    .sts_clr      (sts_clr),
`ifdef VTG_COLORBAR_EN
    .cbar_en      (cbar_en),
`endif
    .sts_underflow(sts_underflow),
    .sts_misalign (sts_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output k of the raster after reset reflects counter position (k-1) mod FR.
  task automatic check_cycle();
    int p, h, v, f, k;
    logic ehs, evs, ede;
    ehs = 1'b0; evs = 1'b0; ede = 1'b0; h = 0; v = 0;
    if (cyc > 0) begin
      p   = (cyc - 1) % FR;
      h   = p % HT;
      v   = p / HT;
      ehs = h < 2;
      evs = v < 1;
      ede = (h >= 4) && (h < 4 + HD) && (v >= 2) && (v < 2 + VD);
    end
    chk("hsync", 32'(video_hsync), 32'(ehs));
    chk("vsync", 32'(video_vsync), 32'(evs));
    chk("de", 32'(video_de), 32'(ede));
    if (ede) begin
      f = (cyc - 1) / FR;
      k = (v - 2) * HD + (h - 4);
      if (f < NFR) cap[f*NPIX + k] = {8'h0, video_data};
    end else begin
      chk("blank_data", {8'h0, video_data}, 32'h0);
    end
  endtask

  task automatic step();
    logic acc;
    check_cycle();
    s_valid = (q.size() > 0) && (gap_cyc != cyc + 1);
    if (q.size() > 0) begin
      s_data = q[0].d;
      s_sof  = q[0].sof;
    end else begin
      s_data = 24'($urandom);
      s_sof  = 1'b0;
    end
    sts_clr = (clr_cyc == cyc + 1);
    #1;
    acc = s_valid & s_ready;
    @(posedge clk);
    cyc++;
    if (acc) begin
      q.delete(0);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic push(input int n, input logic sof_first);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d   = 24'($urandom);
      b.sof = (i == 0) && sof_first;
      q.push_back(b);
      bd.push_back(b.d);
    end
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    s_valid = 1'b1;
    s_sof   = 1'b0;
    s_data  = 24'($urandom);
    sts_clr = 1'b0;
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_vsync", 32'(video_vsync), 32'd0);
    chk("rst_hsync", 32'(video_hsync), 32'd0);
    chk("rst_de", 32'(video_de), 32'd0);
    chk("rst_data", {8'h0, video_data}, 32'h0);
    chk("rst_underflow", 32'(sts_underflow), 32'd0);
    chk("rst_misalign", 32'(sts_misalign), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_ready", 32'(s_ready), 32'd0);
    rst     = 1'b0;
    s_valid = 1'b0;
    cyc     = 0;
    n_acc   = 0;
    gap_cyc = -1;
    clr_cyc = -1;
    q.delete();
    bd.delete();
    for (int i = 0; i < NFR*NPIX; i++) begin
      cap[i]  = 32'hFFFFFFFF;
      expv[i] = 32'h0;
    end
  endtask

  task automatic check_frames(input int nf);
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < NPIX; k++)
        chk($sformatf("f%0d_px%0d", f, k), cap[f*NPIX + k], expv[f*NPIX + k]);
  endtask

  initial begin
    @(negedge clk);

    // idle raster, no stream
    reset_dut();
    repeat (2*FR + 15) step();
    check_frames(2);
    chk("t1_underflow", 32'(sts_underflow), 32'd0);
    chk("t1_misalign", 32'(sts_misalign), 32'd0);
    chk("t1_acc", 32'(n_acc), 32'd0);

    // continuous frame-tagged stream, locked from the second frame
    reset_dut();
    push(NPIX, 1'b1); push(NPIX, 1'b1); push(NPIX, 1'b1);
    for (int f = 1; f < 4; f++)
      for (int k = 0; k < NPIX; k++) expv[f*NPIX + k] = {8'h0, bd[(f-1)*NPIX + k]};
    repeat (4*FR + 15) step();
    check_frames(4);
    chk("t2_underflow", 32'(sts_underflow), 32'd0);
    chk("t2_misalign", 32'(sts_misalign), 32'd0);
    chk("t2_acc", 32'(n_acc), 32'd96);

    // one-cycle valid gap on line 1, column 3 of frame 1; clear held on the same cycle
    reset_dut();
    push(NPIX, 1'b1); push(NPIX, 1'b1); push(NPIX, 1'b1);
    gap_cyc = FR + 3*HT + 4 + 3 + 1;
    clr_cyc = gap_cyc;
    for (int k = 0; k < NPIX; k++)
      expv[NPIX + k] = (k < 11) ? {8'h0, bd[k]} : (k == 11) ? 32'h0 : {8'h0, bd[k-1]};
    repeat (2*FR + 15) step();
    check_frames(2);
    chk("t3_underflow_set", 32'(sts_underflow), 32'd1);
    chk("t3_misalign", 32'(sts_misalign), 32'd0);
    clr_cyc = cyc + 1;
    step();
    chk("t3_underflow_clr", 32'(sts_underflow), 32'd0);

    // leading untagged beats are dropped while seeking
    reset_dut();
    push(5, 1'b0); push(NPIX, 1'b1);
    for (int k = 0; k < NPIX; k++) expv[NPIX + k] = {8'h0, bd[5 + k]};
    repeat (6) step();
    chk("t4_dropped", 32'(n_acc), 32'd5);
    repeat (2*FR + 15 - 6) step();
    check_frames(2);
    chk("t4_acc", 32'(n_acc), 32'd37);
    chk("t4_underflow", 32'(sts_underflow), 32'd0);
    chk("t4_misalign", 32'(sts_misalign), 32'd0);

    // SOF arriving on active pixel 10 of a running frame
    reset_dut();
    push(10, 1'b1); push(NPIX, 1'b1); push(NPIX, 1'b1);
    for (int k = 0; k < NPIX; k++) begin
      expv[NPIX + k]   = (k < 10) ? {8'h0, bd[k]} : 32'h0;
      expv[2*NPIX + k] = {8'h0, bd[10 + k]};
      expv[3*NPIX + k] = {8'h0, bd[42 + k]};
    end
    repeat (4*FR + 15) step();
    check_frames(4);
    chk("t5_misalign", 32'(sts_misalign), 32'd1);
    chk("t5_underflow", 32'(sts_underflow), 32'd0);
    chk("t5_acc", 32'(n_acc), 32'd74);

`ifdef VTG_COLORBAR_EN
    // colour bars override the stream
    reset_dut();
    cbar_en = 1'b1;
    push(1, 1'b0); push(NPIX, 1'b1);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < NPIX; k++) expv[f*NPIX + k] = {8'h0, bars[k % HD]};
    repeat (2*FR + 15) step();
    check_frames(2);
    chk("t6_acc", 32'(n_acc), 32'd0);
    chk("t6_underflow", 32'(sts_underflow), 32'd0);
    chk("t6_misalign", 32'(sts_misalign), 32'd0);
    cbar_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
